hilo_muldiv_sequencer: RTL and testbench

Multi-cycle controller for the HI/LO resource in the 5-stage pipeline. It accepts MULT/MULTU/DIV/DIVU from the EX stage and runs an iterative 32-step shift-add multiply or restoring divide. It then writes the 64-bit result to HI_Reg/LO_Reg through a single write pulse. While busy, it stalls the pipeline front end when a later instruction reads HI/LO or issues another mul/div.

---
 rtl/hilo_pkg.sv | 32 +++
 rtl/muldiv_step.sv | 44 ++++
 rtl/hilo_muldiv_sequencer.sv | 153 +++++++++++++++
 tb/tb_hilo_muldiv_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
//   op_t    : EX-stage op_code encodings for MULT/MULTU/DIV/DIVU
//   state_t : sequencer FSM states
//   DIV0_LO : LO value written when a divide has a zero divisor
package hilo_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        CALC  = 3'd2,
        FIXUP = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [31:0] DIV0_LO = '1;

    function automatic logic op_is_div(input op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_t op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the unsigned shift-add multiplier or
// restoring divider.
//   acc      : 2*WIDTH accumulator
//              multiply: {partial product high, remaining multiplier bits}
//              divide  : {partial remainder, remaining dividend / quotient bits}
//   operand  : multiplicand (multiply) or divisor (divide), unsigned magnitude
//   is_div   : 1 selects the divide step
//   acc_next : accumulator after this iteration
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   rem_diff;
    logic               rem_ge;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        // Multiply: add multiplicand into the high half when the current
        // multiplier LSB is set, then shift the carry back into the top.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        // Divide: shift the next dividend bit into the remainder. The
        // difference only needs WIDTH bits because it is kept only when
        // non-negative, and the remainder is always below the divisor.
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, operand});
        rem_diff  = rem_shift[WIDTH-1:0] - operand;
        div_next  = {(rem_ge ? rem_diff : rem_shift[WIDTH-1:0]),
                     acc[WIDTH-2:0], rem_ge};

        acc_next = is_div ? div_next : mul_next;
    end

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// Multi-cycle HI/LO controller: iterative MULT/MULTU/DIV/DIVU with a single
// HI/LO write strobe and front-end stall generation.
//   Clk, Rst     : clock (rising edge), asynchronous active-low reset
//   op_valid     : EX holds a mul/div this cycle
//   op_code      : 0=MULT 1=MULTU 2=DIV 3=DIVU
//   operand_a/b  : rs / rt values
//   hilo_read    : ID or EX holds MFHI/MFLO
//   stall        : hold PC, IF_ID, ID_EX
//   busy         : sequencer not idle
//   hi_wdata/lo_wdata, hilo_we : HI/LO write data and strobe
//   div_by_zero  : flags a zero-divisor divide alongside hilo_we
module hilo_muldiv_sequencer
    import hilo_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hilo_read,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi_wdata,
    output logic [WIDTH-1:0] lo_wdata,
    output logic             hilo_we,
    output logic             div_by_zero
);

    state_t             state, state_nxt;
    op_t                op_q;
    logic [WIDTH-1:0]   a_q, b_q, opnd_q;
    logic [2*WIDTH-1:0] acc, acc_step;
    logic [CNT_W-1:0]   cnt;
    logic               sign_q, sign_r, dbz_q;

    logic               is_div, is_signed, b_zero, last_iter;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, hi_res, lo_res;

    assign is_div    = op_is_div(op_q);
    assign is_signed = op_is_signed(op_q);
    assign b_zero    = (b_q == '0);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // Magnitudes; 0x80000000 maps to itself, which is the correct unsigned
    // magnitude, so the most negative operand needs no special case.
    assign a_mag = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    assign b_mag = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (opnd_q),
        .is_div   (is_div),
        .acc_next (acc_step)
    );

    // Sign correction of the unsigned result. sign_q/sign_r are cleared
    // for unsigned ops, so this is transparent for MULTU/DIVU.
    always_comb begin
        prod_fix = sign_q ? -acc : acc;
        quo_fix  = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        hi_res   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_res   = is_div ? quo_fix : prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        stall       = 1'b0;
        hilo_we     = 1'b0;
        div_by_zero = 1'b0;

        unique case (state)
            IDLE:    if (op_valid) state_nxt = PREP;
            PREP:    state_nxt = (is_div && b_zero) ? DONE : CALC;
            CALC:    if (last_iter) state_nxt = FIXUP;
            FIXUP:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        busy        = (state != IDLE);
        stall       = busy & (hilo_read | op_valid);
        hilo_we     = (state == DONE);
        div_by_zero = hilo_we & dbz_q;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            op_q     <= OP_MULT;
            a_q      <= '0;
            b_q      <= '0;
            opnd_q   <= '0;
            acc      <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_wdata <= '0;
            lo_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (op_valid) begin
                        op_q  <= op_t'(op_code);
                        a_q   <= operand_a;
                        b_q   <= operand_b;
                        dbz_q <= 1'b0;
                    end
                end
                PREP: begin
                    sign_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    sign_r <= is_signed & a_q[WIDTH-1];
                    cnt    <= '0;
                    if (is_div && b_zero) begin
                        hi_wdata <= a_q;
                        lo_wdata <= WIDTH'(DIV0_LO);
                        dbz_q    <= 1'b1;
                    end else begin
                        // Divide iterates on the dividend against the divisor;
                        // multiply consumes the multiplier against the multiplicand.
                        opnd_q <= is_div ? b_mag : a_mag;
                        acc    <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    if (!last_iter) cnt <= cnt + CNT_W'(1);
                end
                FIXUP: begin
                    hi_wdata <= hi_res;
                    lo_wdata <= lo_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Directed self-checking bench for hilo_muldiv_sequencer. Cycle 0 is the
// accept cycle; inputs change 1 time unit after the rising edge and outputs
// are sampled on the falling edge.
module tb_hilo_muldiv_sequencer;

    logic        Clk, Rst, op_valid, hilo_read;
    logic [1:0]  op_code;
    logic [31:0] operand_a, operand_b;
    logic        stall, busy, hilo_we, div_by_zero;
    logic [31:0] hi_wdata, lo_wdata;

    int vectors     = 0;
    int miscompares = 0;

    hilo_muldiv_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .op_valid    (op_valid),
        .op_code     (op_code),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .hilo_read   (hilo_read),
        .stall       (stall),
        .busy        (busy),
        .hi_wdata    (hi_wdata),
        .lo_wdata    (lo_wdata),
        .hilo_we     (hilo_we),
        .div_by_zero (div_by_zero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Issues one op in cycle 0 and observes 40 cycles; records observations
    // only, every task does its own comparisons.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int we_cyc, output int we_cnt,
                          output logic [31:0] hi, output logic [31:0] lo, output logic dbz,
                          output logic [39:0] busy_m, output logic [39:0] stall_m);
        we_cyc = -1; we_cnt = 0; hi = '0; lo = '0; dbz = 1'b0;
        busy_m = '0; stall_m = '0;
        for (int c = 0; c < 40; c++) begin
            op_valid  = (c == 0);
            op_code   = op;
            operand_a = a;
            operand_b = b;
            hilo_read = 1'b0;
            @(negedge Clk);
            busy_m[c]  = busy;
            stall_m[c] = stall;
            if (hilo_we) begin
                we_cnt++;
                if (we_cyc < 0) begin
                    we_cyc = c; hi = hi_wdata; lo = lo_wdata; dbz = div_by_zero;
                end
            end
            @(posedge Clk); #1;
        end
        op_valid = 1'b0;
    endtask

    task automatic test_reset;
        Rst = 1'b0; op_valid = 1'b1; hilo_read = 1'b1; op_code = 2'd3;
        operand_a = 32'd5; operand_b = 32'd0;
        @(negedge Clk);
        vectors++;
        if ({busy, stall, hilo_we, div_by_zero} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 0000", {busy, stall, hilo_we, div_by_zero});
        end
        vectors++;
        if ({hi_wdata, lo_wdata} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected 0", {hi_wdata, lo_wdata});
        end
        @(posedge Clk); #1;
        op_valid = 1'b0; hilo_read = 1'b0; Rst = 1'b1;
        @(posedge Clk); #1;
    endtask

    task automatic test_multu;
        int wc, wn; logic [31:0] hi, lo; logic dz; logic [39:0] bm, sm;
        logic [39:0] busy_exp;
        busy_exp = 40'h0F_FFFF_FFFE;  // cycles 1..35
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, wc, wn, hi, lo, dz, bm, sm);
        vectors++;
        if (wc !== 35) begin miscompares++; $display("FAIL multu_latency: got %0d expected 35", wc); end
        vectors++;
        if (wn !== 1) begin miscompares++; $display("FAIL multu_we_count: got %0d expected 1", wn); end
        vectors++;
        if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
            miscompares++; $display("FAIL multu_result: got %h expected fffffffe00000001", {hi, lo});
        end
        vectors++;
        if (dz !== 1'b0) begin miscompares++; $display("FAIL multu_dbz: got %b expected 0", dz); end
        vectors++;
        if (bm !== busy_exp) begin miscompares++; $display("FAIL multu_busy: got %h expected %h", bm, busy_exp); end
        vectors++;
        if (sm !== 40'd0) begin miscompares++; $display("FAIL multu_stall: got %h expected 0", sm); end
    endtask

    task automatic test_mult;
        logic [31:0] av[2] = '{32'hFFFF_FFFD, 32'h8000_0000};
        logic [31:0] bv[2] = '{32'h0000_0007, 32'h8000_0000};
        logic [63:0] ev[2] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'h4000_0000_0000_0000};
        int wc, wn; logic [31:0] hi, lo; logic dz; logic [39:0] bm, sm;
        for (int i = 0; i < 2; i++) begin
            run_op(2'd0, av[i], bv[i], wc, wn, hi, lo, dz, bm, sm);
            vectors++;
            if (wc !== 35) begin miscompares++; $display("FAIL mult%0d_latency: got %0d expected 35", i, wc); end
            vectors++;
            if ({hi, lo} !== ev[i]) begin
                miscompares++; $display("FAIL mult%0d_result: got %h expected %h", i, {hi, lo}, ev[i]);
            end
        end
    endtask

    task automatic test_div;
        logic [1:0]  ov[3] = '{2'd2, 2'd3, 2'd2};
        logic [31:0] av[3] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000};
        logic [31:0] bv[3] = '{32'd2, 32'd7, 32'hFFFF_FFFF};
        logic [63:0] ev[3] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0002_0000_000E,
                               64'h0000_0000_8000_0000};
        int wc, wn; logic [31:0] hi, lo; logic dz; logic [39:0] bm, sm;
        for (int i = 0; i < 3; i++) begin
            run_op(ov[i], av[i], bv[i], wc, wn, hi, lo, dz, bm, sm);
            vectors++;
            if (wc !== 35) begin miscompares++; $display("FAIL div%0d_latency: got %0d expected 35", i, wc); end
            vectors++;
            if ({hi, lo, dz} !== {ev[i], 1'b0}) begin
                miscompares++;
                $display("FAIL div%0d_result: got %h dbz %b expected %h dbz 0", i, {hi, lo}, dz, ev[i]);
            end
        end
    endtask

    task automatic test_div_zero;
        int wc, wn; logic [31:0] hi, lo; logic dz; logic [39:0] bm, sm;
        run_op(2'd3, 32'd100, 32'd0, wc, wn, hi, lo, dz, bm, sm);
        vectors++;
        if (wc !== 2) begin miscompares++; $display("FAIL div0_latency: got %0d expected 2", wc); end
        vectors++;
        if (wn !== 1) begin miscompares++; $display("FAIL div0_we_count: got %0d expected 1", wn); end
        vectors++;
        if ({hi, lo} !== 64'h0000_0064_FFFF_FFFF) begin
            miscompares++; $display("FAIL div0_result: got %h expected 00000064ffffffff", {hi, lo});
        end
        vectors++;
        if (dz !== 1'b1) begin miscompares++; $display("FAIL div0_flag: got %b expected 1", dz); end
        vectors++;
        if (bm !== 40'h6) begin miscompares++; $display("FAIL div0_busy: got %h expected 6", bm); end
    endtask

    task automatic test_stall;
        logic [79:0] sm, bm;
        int we_seen, we1, we2;
        logic [31:0] hi1, lo1, hi2, lo2;
        sm = '0; bm = '0; we_seen = 0; we1 = -1; we2 = -1;
        hi1 = '0; lo1 = '0; hi2 = '0; lo2 = '0;
        for (int c = 0; c < 80; c++) begin
            if (c == 0) begin
                op_valid = 1'b1; op_code = 2'd1; operand_a = 32'hFFFF_FFFF; operand_b = 32'hFFFF_FFFF;
            end else if (c >= 3 && c <= 36) begin
                op_valid = 1'b1; op_code = 2'd3; operand_a = 32'd100; operand_b = 32'd7;
            end else begin
                op_valid = 1'b0;
            end
            hilo_read = (c >= 5 && c <= 36);
            @(negedge Clk);
            sm[c] = stall;
            bm[c] = busy;
            if (hilo_we) begin
                if (we_seen == 0) begin we1 = c; hi1 = hi_wdata; lo1 = lo_wdata; end
                else if (we_seen == 1) begin we2 = c; hi2 = hi_wdata; lo2 = lo_wdata; end
                we_seen++;
            end
            @(posedge Clk); #1;
        end
        op_valid = 1'b0; hilo_read = 1'b0;
        vectors++;
        if (sm[2:0] !== 3'b000) begin miscompares++; $display("FAIL stall_early: got %b expected 000", sm[2:0]); end
        vectors++;
        if (sm[35:3] !== {33{1'b1}}) begin
            miscompares++; $display("FAIL stall_busy: got %h expected all ones", sm[35:3]);
        end
        vectors++;
        if (sm[36] !== 1'b0) begin miscompares++; $display("FAIL stall_idle_accept: got %b expected 0", sm[36]); end
        vectors++;
        if (bm[37] !== 1'b1) begin miscompares++; $display("FAIL second_accept: got %b expected 1", bm[37]); end
        vectors++;
        if (we1 !== 35 || {hi1, lo1} !== 64'hFFFF_FFFE_0000_0001) begin
            miscompares++;
            $display("FAIL stall_first_op: got cycle %0d %h expected cycle 35 fffffffe00000001", we1, {hi1, lo1});
        end
        vectors++;
        if (we2 !== 71 || {hi2, lo2} !== 64'h0000_0002_0000_000E) begin
            miscompares++;
            $display("FAIL stall_second_op: got cycle %0d %h expected cycle 71 000000020000000e", we2, {hi2, lo2});
        end
        vectors++;
        if (we_seen !== 2) begin miscompares++; $display("FAIL stall_we_count: got %0d expected 2", we_seen); end
    endtask

    task automatic test_reset_mid;
        int we_n; int wc, wn; logic [31:0] hi, lo; logic dz; logic [39:0] bm, sm;
        we_n = 0;
        for (int c = 0; c < 40; c++) begin
            op_valid = (c == 0); op_code = 2'd2;
            operand_a = 32'hFFFF_FFF9; operand_b = 32'd2;
            if (c == 20) begin
                hilo_read = 1'b1;
                #2 Rst = 1'b0;
            end
            @(negedge Clk);
            if (c == 19) begin
                vectors++;
                if (busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
            end
            if (c == 20) begin
                vectors++;
                if ({busy, stall, hilo_we, div_by_zero} !== 4'b0000) begin
                    miscompares++;
                    $display("FAIL rstmid_ctrl: got %b expected 0000", {busy, stall, hilo_we, div_by_zero});
                end
                vectors++;
                if ({hi_wdata, lo_wdata} !== 64'd0) begin
                    miscompares++; $display("FAIL rstmid_data: got %h expected 0", {hi_wdata, lo_wdata});
                end
            end
            if (hilo_we) we_n++;
            @(posedge Clk); #1;
            if (c == 20) begin
                Rst = 1'b1; hilo_read = 1'b0;
            end
        end
        vectors++;
        if (we_n !== 0) begin miscompares++; $display("FAIL rstmid_no_we: got %0d expected 0", we_n); end
        run_op(2'd3, 32'd100, 32'd7, wc, wn, hi, lo, dz, bm, sm);
        vectors++;
        if (wc !== 35 || {hi, lo} !== 64'h0000_0002_0000_000E) begin
            miscompares++;
            $display("FAIL rstmid_fresh_op: got cycle %0d %h expected cycle 35 000000020000000e", wc, {hi, lo});
        end
    endtask

    initial begin
        Rst = 1'b0; op_valid = 1'b0; hilo_read = 1'b0; op_code = 2'd0;
        operand_a = '0; operand_b = '0;
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
